// File: rtl/voice_alloc.sv
// Polyphonic voice allocator: maps MIDI note-on/off events onto VOICES generator slots, stealing the oldest when full.
// Latency: VOICES+1 clock edges from midi_rdy to the voice_upd strobe (one scan cycle per voice plus a commit).
// Backpressure: none upstream; events arriving while busy are dropped and flagged by the sticky overflow bit.

`ifndef MIDI_CMD_SIZE
`define MIDI_CMD_SIZE 3
`endif
`ifndef MIDI_CMD_NOTE_OFF
`define MIDI_CMD_NOTE_OFF 3'd1
`endif
`ifndef MIDI_CMD_NOTE_ON
`define MIDI_CMD_NOTE_ON 3'd2
`endif

module voice_alloc #(
    parameter int VOICES  = 4,
    parameter int CHANNEL = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      midi_rdy,
    input  logic [`MIDI_CMD_SIZE-1:0] midi_cmd,
    input  logic [3:0]                midi_ch_sysn,
    input  logic [6:0]                midi_data0,
    input  logic [6:0]                midi_data1,
    output logic [VOICES*7-1:0]       voice_note,
    output logic [VOICES*7-1:0]       voice_vel,
    output logic [VOICES-1:0]         voice_gate,
    output logic                      voice_upd,
    output logic [2:0]                voice_upd_idx,
    output logic                      busy,
    output logic                      overflow
);

    localparam int            SW   = (VOICES > 1) ? $clog2(VOICES) : 1;
    localparam logic [SW-1:0] LAST = SW'(VOICES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t state_q, state_d;

    // latched event and scan bookkeeping
    logic [SW-1:0] scan_idx_q, scan_idx_d;
    logic          ev_on_q, ev_on_d;
    logic [6:0]    ev_note_q, ev_note_d;
    logic [6:0]    ev_vel_q, ev_vel_d;
    logic          match_found_q, match_found_d;
    logic [SW-1:0] match_idx_q, match_idx_d;
    logic          free_found_q, free_found_d;
    logic [SW-1:0] free_idx_q, free_idx_d;
    logic [SW-1:0] old_idx_q, old_idx_d;
    logic [7:0]    old_age_q, old_age_d;

    // per-voice state
    logic [6:0]        note_q [VOICES];
    logic [6:0]        note_d [VOICES];
    logic [6:0]        vel_q  [VOICES];
    logic [6:0]        vel_d  [VOICES];
    logic [7:0]        age_q  [VOICES];
    logic [7:0]        age_d  [VOICES];
    logic [VOICES-1:0] gate_q, gate_d;

    logic       upd_q, upd_d;
    logic [2:0] upd_idx_q, upd_idx_d;
    logic       overflow_q, overflow_d;

    logic          is_on, is_off, ch_ok, accept;
    logic          hit;
    logic [SW-1:0] tgt;

    // event qualification: note commands on the selected channel (or any in omni mode)
    always_comb begin
        is_on  = (midi_cmd == `MIDI_CMD_NOTE_ON);
        is_off = (midi_cmd == `MIDI_CMD_NOTE_OFF);
        ch_ok  = (CHANNEL == 16) || (midi_ch_sysn == 4'(CHANNEL));
        accept = midi_rdy && (is_on || is_off) && ch_ok;
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: one scan cycle per voice, then a single commit cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SCAN;
            SCAN:    if (scan_idx_q == LAST) state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs and flattening of per-voice state onto the packed output buses
    always_comb begin
        busy          = (state_q != IDLE);
        voice_upd     = upd_q;
        voice_upd_idx = upd_idx_q;
        overflow      = overflow_q;
        voice_gate    = gate_q;
        voice_note    = '0;
        voice_vel     = '0;
        for (int i = 0; i < VOICES; i++) begin
            voice_note[7*i +: 7] = note_q[i];
            voice_vel[7*i +: 7]  = vel_q[i];
        end
    end

    // event latch and per-cycle scan: track first match, lowest free and oldest voice
    always_comb begin
        scan_idx_d    = scan_idx_q;
        ev_on_d       = ev_on_q;
        ev_note_d     = ev_note_q;
        ev_vel_d      = ev_vel_q;
        match_found_d = match_found_q;
        match_idx_d   = match_idx_q;
        free_found_d  = free_found_q;
        free_idx_d    = free_idx_q;
        old_idx_d     = old_idx_q;
        old_age_d     = old_age_q;
        hit           = gate_q[scan_idx_q] && (note_q[scan_idx_q] == ev_note_q);

        if (state_q == IDLE && accept) begin
            scan_idx_d = '0;
            // velocity-zero note-on is the running-status idiom for note-off
            ev_on_d    = is_on && (midi_data1 != 7'd0);
            ev_note_d  = midi_data0;
            ev_vel_d   = midi_data1;
        end

        if (state_q == SCAN) begin
            scan_idx_d = scan_idx_q + 1'b1;
            if (scan_idx_q == '0) begin
                // first voice seeds all three candidates
                match_found_d = hit;
                match_idx_d   = scan_idx_q;
                free_found_d  = !gate_q[scan_idx_q];
                free_idx_d    = scan_idx_q;
                old_idx_d     = scan_idx_q;
                old_age_d     = age_q[scan_idx_q];
            end else begin
                if (!match_found_q && hit) begin
                    match_found_d = 1'b1;
                    match_idx_d   = scan_idx_q;
                end
                if (!free_found_q && !gate_q[scan_idx_q]) begin
                    free_found_d = 1'b1;
                    free_idx_d   = scan_idx_q;
                end
                // strict compare keeps the lowest index on equal ages
                if (age_q[scan_idx_q] > old_age_q) begin
                    old_idx_d = scan_idx_q;
                    old_age_d = age_q[scan_idx_q];
                end
            end
        end
    end

    // commit: apply the selected voice write, age the rest, raise the update strobe
    always_comb begin
        for (int i = 0; i < VOICES; i++) begin
            note_d[i] = note_q[i];
            vel_d[i]  = vel_q[i];
            age_d[i]  = age_q[i];
        end
        gate_d     = gate_q;
        upd_d      = 1'b0;
        upd_idx_d  = upd_idx_q;
        overflow_d = overflow_q | (accept && (state_q != IDLE));
        tgt        = match_found_q ? match_idx_q : (free_found_q ? free_idx_q : old_idx_q);

        if (state_q == COMMIT) begin
            if (ev_on_q) begin
                for (int i = 0; i < VOICES; i++) begin
                    if (SW'(i) == tgt) begin
                        note_d[i] = ev_note_q;
                        vel_d[i]  = ev_vel_q;
                        age_d[i]  = 8'd0;
                        gate_d[i] = 1'b1;
                    end else if (age_q[i] != 8'hFF) begin
                        age_d[i] = age_q[i] + 8'd1;
                    end
                end
                upd_d     = 1'b1;
                upd_idx_d = 3'(tgt);
            end else if (match_found_q) begin
                gate_d[match_idx_q] = 1'b0;
                upd_d               = 1'b1;
                upd_idx_d           = 3'(match_idx_q);
            end
        end
    end

    // datapath registers; reset mid-event discards everything latched so far
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scan_idx_q    <= '0;
            ev_on_q       <= 1'b0;
            ev_note_q     <= '0;
            ev_vel_q      <= '0;
            match_found_q <= 1'b0;
            match_idx_q   <= '0;
            free_found_q  <= 1'b0;
            free_idx_q    <= '0;
            old_idx_q     <= '0;
            old_age_q     <= '0;
            gate_q        <= '0;
            upd_q         <= 1'b0;
            upd_idx_q     <= '0;
            overflow_q    <= 1'b0;
            for (int i = 0; i < VOICES; i++) begin
                note_q[i] <= '0;
                vel_q[i]  <= '0;
                age_q[i]  <= '0;
            end
        end else begin
            scan_idx_q    <= scan_idx_d;
            ev_on_q       <= ev_on_d;
            ev_note_q     <= ev_note_d;
            ev_vel_q      <= ev_vel_d;
            match_found_q <= match_found_d;
            match_idx_q   <= match_idx_d;
            free_found_q  <= free_found_d;
            free_idx_q    <= free_idx_d;
            old_idx_q     <= old_idx_d;
            old_age_q     <= old_age_d;
            gate_q        <= gate_d;
            upd_q         <= upd_d;
            upd_idx_q     <= upd_idx_d;
            overflow_q    <= overflow_d;
            for (int i = 0; i < VOICES; i++) begin
                note_q[i] <= note_d[i];
                vel_q[i]  <= vel_d[i];
                age_q[i]  <= age_d[i];
            end
        end
    end

endmodule

// File: tb/tb_voice_alloc.sv
// Directed bench for voice_alloc: an omni 4-voice instance plus a channel-3 instance on shared inputs.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Each scenario task checks its own expectations inline.

`ifndef MIDI_CMD_SIZE
`define MIDI_CMD_SIZE 3
`endif
`ifndef MIDI_CMD_NOTE_OFF
`define MIDI_CMD_NOTE_OFF 3'd1
`endif
`ifndef MIDI_CMD_NOTE_ON
`define MIDI_CMD_NOTE_ON 3'd2
`endif

module tb_voice_alloc;

    logic                      clk = 1'b0;
    logic                      reset_n = 1'b0;
    logic                      midi_rdy = 1'b0;
    logic [`MIDI_CMD_SIZE-1:0] midi_cmd = '0;
    logic [3:0]                midi_ch_sysn = '0;
    logic [6:0]                midi_data0 = '0;
    logic [6:0]                midi_data1 = '0;

    logic [27:0] voice_note, voice_vel;
    logic [3:0]  voice_gate;
    logic        voice_upd, busy, overflow;
    logic [2:0]  voice_upd_idx;

    logic [27:0] c3_note, c3_vel;
    logic [3:0]  c3_gate;
    logic        c3_upd, c3_busy, c3_overflow;
    logic [2:0]  c3_upd_idx;

    int total = 0;
    int bad   = 0;

    localparam logic [2:0] ON  = `MIDI_CMD_NOTE_ON;
    localparam logic [2:0] OFF = `MIDI_CMD_NOTE_OFF;

    always #5 clk = ~clk;

    voice_alloc #(.VOICES(4), .CHANNEL(16)) dut (
        .clk(clk), .reset_n(reset_n), .midi_rdy(midi_rdy), .midi_cmd(midi_cmd),
        .midi_ch_sysn(midi_ch_sysn), .midi_data0(midi_data0), .midi_data1(midi_data1),
        .voice_note(voice_note), .voice_vel(voice_vel), .voice_gate(voice_gate),
        .voice_upd(voice_upd), .voice_upd_idx(voice_upd_idx), .busy(busy), .overflow(overflow)
    );

    voice_alloc #(.VOICES(4), .CHANNEL(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .midi_rdy(midi_rdy), .midi_cmd(midi_cmd),
        .midi_ch_sysn(midi_ch_sysn), .midi_data0(midi_data0), .midi_data1(midi_data1),
        .voice_note(c3_note), .voice_vel(c3_vel), .voice_gate(c3_gate),
        .voice_upd(c3_upd), .voice_upd_idx(c3_upd_idx), .busy(c3_busy), .overflow(c3_overflow)
    );

    task automatic apply_reset();
        midi_rdy = 1'b0;
        reset_n  = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    // called on a falling edge; returns on the falling edge after the accepting rising edge
    task automatic strobe(input logic [2:0] cmd, input logic [3:0] ch,
                          input logic [6:0] n, input logic [6:0] v);
        midi_cmd     = cmd;
        midi_ch_sysn = ch;
        midi_data0   = n;
        midi_data1   = v;
        midi_rdy     = 1'b1;
        @(negedge clk);
        midi_rdy = 1'b0;
    endtask

    // one event plus a bounded 12-cycle observation window on the omni instance
    task automatic run_event(input logic [2:0] cmd, input logic [3:0] ch,
                             input logic [6:0] n, input logic [6:0] v,
                             output int lat, output int nupd, output int bcyc,
                             output logic [2:0] idx);
        strobe(cmd, ch, n, v);
        lat  = -1;
        nupd = 0;
        idx  = 3'd0;
        bcyc = busy ? 1 : 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (busy) bcyc++;
            if (voice_upd) begin
                nupd++;
                if (lat < 0) begin
                    lat = k;
                    idx = voice_upd_idx;
                end
            end
        end
    endtask

    task automatic test_reset();
        apply_reset();
        total++; if (voice_note !== 28'h0) begin bad++; $display("FAIL reset_note got=%0h want=0", voice_note); end
        total++; if (voice_vel !== 28'h0) begin bad++; $display("FAIL reset_vel got=%0h want=0", voice_vel); end
        total++; if ({voice_gate, voice_upd, voice_upd_idx, busy, overflow} !== 10'h0) begin
            bad++; $display("FAIL reset_ctrl got=%0h want=0", {voice_gate, voice_upd, voice_upd_idx, busy, overflow});
        end
    endtask

    task automatic test_first_note();
        int lat, nupd, bcyc;
        logic [2:0] idx;
        apply_reset();
        run_event(ON, 4'd0, 7'h45, 7'h40, lat, nupd, bcyc, idx);
        total++; if (lat !== 5) begin bad++; $display("FAIL first_latency got=%0d want=5", lat); end
        total++; if (nupd !== 1) begin bad++; $display("FAIL first_upd_count got=%0d want=1", nupd); end
        total++; if (idx !== 3'd0) begin bad++; $display("FAIL first_idx got=%0d want=0", idx); end
        total++; if (bcyc !== 5) begin bad++; $display("FAIL first_busy_cycles got=%0d want=5", bcyc); end
        total++; if (voice_note[6:0] !== 7'h45) begin bad++; $display("FAIL first_note got=%0h want=45", voice_note[6:0]); end
        total++; if (voice_vel[6:0] !== 7'h40) begin bad++; $display("FAIL first_vel got=%0h want=40", voice_vel[6:0]); end
        total++; if (voice_gate !== 4'b0001) begin bad++; $display("FAIL first_gate got=%b want=0001", voice_gate); end
    endtask

    task automatic test_steal();
        int lat, nupd, bcyc;
        logic [2:0] idx;
        logic [6:0] notes [5];
        logic [2:0] want  [5];
        notes = '{7'h30, 7'h32, 7'h34, 7'h35, 7'h37};
        want  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
        apply_reset();
        for (int e = 0; e < 5; e++) begin
            run_event(ON, 4'd0, notes[e], 7'h50, lat, nupd, bcyc, idx);
            total++; if (idx !== want[e] || nupd !== 1) begin
                bad++; $display("FAIL steal_idx[%0d] got=%0d/%0d want=%0d/1", e, idx, nupd, want[e]);
            end
        end
        total++; if (voice_note !== {7'h35, 7'h34, 7'h32, 7'h37}) begin
            bad++; $display("FAIL steal_notes got=%0h want=%0h", voice_note, {7'h35, 7'h34, 7'h32, 7'h37});
        end
        total++; if (voice_gate !== 4'b1111) begin bad++; $display("FAIL steal_gate got=%b want=1111", voice_gate); end
    endtask

    task automatic test_note_off();
        int lat, nupd, bcyc;
        logic [2:0] idx;
        apply_reset();
        run_event(ON, 4'd0, 7'h30, 7'h20, lat, nupd, bcyc, idx);
        run_event(ON, 4'd0, 7'h32, 7'h21, lat, nupd, bcyc, idx);
        run_event(OFF, 4'd0, 7'h32, 7'h00, lat, nupd, bcyc, idx);
        total++; if (idx !== 3'd1 || nupd !== 1 || lat !== 5) begin
            bad++; $display("FAIL off_upd got=idx%0d n%0d lat%0d want=idx1 n1 lat5", idx, nupd, lat);
        end
        total++; if (voice_gate !== 4'b0001) begin bad++; $display("FAIL off_gate got=%b want=0001", voice_gate); end
        total++; if (voice_note[13:7] !== 7'h32 || voice_vel[13:7] !== 7'h21) begin
            bad++; $display("FAIL off_keep got=%0h/%0h want=32/21", voice_note[13:7], voice_vel[13:7]);
        end
        run_event(OFF, 4'd0, 7'h50, 7'h00, lat, nupd, bcyc, idx);
        total++; if (nupd !== 0) begin bad++; $display("FAIL off_nomatch_upd got=%0d want=0", nupd); end
        total++; if (voice_gate !== 4'b0001 || voice_note[13:0] !== {7'h32, 7'h30}) begin
            bad++; $display("FAIL off_nomatch_state got=%b/%0h want=0001/%0h", voice_gate, voice_note[13:0], {7'h32, 7'h30});
        end
        run_event(ON, 4'd0, 7'h30, 7'h00, lat, nupd, bcyc, idx);
        total++; if (voice_gate !== 4'b0000 || idx !== 3'd0 || nupd !== 1) begin
            bad++; $display("FAIL vel0_off got=%b idx%0d n%0d want=0000 idx0 n1", voice_gate, idx, nupd);
        end
    endtask

    task automatic test_retrigger();
        int lat, nupd, bcyc;
        logic [2:0] idx;
        apply_reset();
        run_event(ON, 4'd0, 7'h40, 7'h10, lat, nupd, bcyc, idx);
        run_event(ON, 4'd0, 7'h40, 7'h7F, lat, nupd, bcyc, idx);
        total++; if (idx !== 3'd0) begin bad++; $display("FAIL retrig_idx got=%0d want=0", idx); end
        total++; if (voice_vel[6:0] !== 7'h7F) begin bad++; $display("FAIL retrig_vel got=%0h want=7f", voice_vel[6:0]); end
        total++; if (voice_gate !== 4'b0001) begin bad++; $display("FAIL retrig_gate got=%b want=0001", voice_gate); end
    endtask

    task automatic test_overflow();
        int lat, nupd, bcyc;
        logic [2:0] idx;
        apply_reset();
        midi_cmd = ON; midi_ch_sysn = 4'd0; midi_data0 = 7'h20; midi_data1 = 7'h33; midi_rdy = 1'b1;
        @(negedge clk);
        midi_cmd = 3'd5;                       // not a note command while busy
        @(negedge clk);
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_other_cmd got=%b want=0", overflow); end
        midi_cmd = ON; midi_data0 = 7'h22;     // second note-on two cycles after the first
        @(negedge clk);
        midi_rdy = 1'b0;
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b want=1", overflow); end
        nupd = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (voice_upd) nupd++;
        end
        total++; if (nupd !== 1) begin bad++; $display("FAIL ovf_upd_count got=%0d want=1", nupd); end
        total++; if (voice_note[6:0] !== 7'h20 || voice_gate !== 4'b0001) begin
            bad++; $display("FAIL ovf_state got=%0h/%b want=20/0001", voice_note[6:0], voice_gate);
        end
        run_event(ON, 4'd0, 7'h24, 7'h33, lat, nupd, bcyc, idx);
        total++; if (idx !== 3'd1 || overflow !== 1'b1) begin
            bad++; $display("FAIL ovf_sticky got=idx%0d ovf%b want=idx1 ovf1", idx, overflow);
        end
        total++; if (c3_overflow !== 1'b0) begin bad++; $display("FAIL ovf_ch3_clean got=%b want=0", c3_overflow); end
    endtask

    task automatic test_commit_boundary();
        int nupd;
        apply_reset();
        strobe(ON, 4'd0, 7'h10, 7'h11);        // now just past E0
        repeat (4) @(negedge clk);             // just past E4: FSM in COMMIT
        midi_cmd = ON; midi_data0 = 7'h12; midi_rdy = 1'b1;
        @(negedge clk);                        // just past E5: IDLE again
        total++; if (voice_upd !== 1'b1 || overflow !== 1'b1) begin
            bad++; $display("FAIL commit_drop got=upd%b ovf%b want=upd1 ovf1", voice_upd, overflow);
        end
        midi_data0 = 7'h14;
        @(negedge clk);
        midi_rdy = 1'b0;
        nupd = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (voice_upd) nupd++;
        end
        total++; if (nupd !== 1 || voice_gate !== 4'b0011 || voice_note[13:0] !== {7'h14, 7'h10}) begin
            bad++; $display("FAIL after_commit got=n%0d g%b note%0h want=n1 g0011 note%0h", nupd, voice_gate, voice_note[13:0], {7'h14, 7'h10});
        end
    endtask

    task automatic test_channel();
        apply_reset();
        strobe(ON, 4'd5, 7'h11, 7'h22);
        total++; if (c3_busy !== 1'b0) begin bad++; $display("FAIL ch_filter_busy got=%b want=0", c3_busy); end
        strobe(ON, 4'd5, 7'h13, 7'h22);
        repeat (10) @(negedge clk);
        total++; if (c3_overflow !== 1'b0 || c3_gate !== 4'b0000 || c3_upd !== 1'b0) begin
            bad++; $display("FAIL ch_filter_state got=ovf%b g%b want=ovf0 g0000", c3_overflow, c3_gate);
        end
        strobe(ON, 4'd3, 7'h11, 7'h22);
        repeat (10) @(negedge clk);
        total++; if (c3_gate !== 4'b0001 || c3_note[6:0] !== 7'h11 || c3_vel[6:0] !== 7'h22 || c3_upd_idx !== 3'd0) begin
            bad++; $display("FAIL ch_match got=g%b note%0h want=g0001 note11", c3_gate, c3_note[6:0]);
        end
    endtask

    task automatic test_reset_mid_scan();
        int lat, nupd, bcyc;
        logic [2:0] idx;
        apply_reset();
        strobe(ON, 4'd0, 7'h60, 7'h44);
        @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL midscan_busy got=%b want=1", busy); end
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        nupd = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (voice_upd) nupd++;
        end
        total++; if (nupd !== 0 || voice_gate !== 4'b0000 || busy !== 1'b0 || voice_note !== 28'h0) begin
            bad++; $display("FAIL midscan_abort got=n%0d g%b busy%b want=n0 g0000 busy0", nupd, voice_gate, busy);
        end
        run_event(ON, 4'd0, 7'h61, 7'h45, lat, nupd, bcyc, idx);
        total++; if (idx !== 3'd0 || lat !== 5 || voice_note[6:0] !== 7'h61) begin
            bad++; $display("FAIL midscan_next got=idx%0d lat%0d note%0h want=idx0 lat5 note61", idx, lat, voice_note[6:0]);
        end
    endtask

    initial begin
        test_reset();
        test_first_note();
        test_steal();
        test_note_off();
        test_retrigger();
        test_overflow();
        test_commit_boundary();
        test_channel();
        test_reset_mid_scan();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
